// File: rtl/led_frame_writer_if.sv
// led_frame_writer_if -- write port into the LED driver's pixel RAM.
//   wten   : write strobe, one cycle per word
//   wtaddr : RAM word address (LED index)
//   wtdina : RAM write data (scaled LED value)
// master = frame writer, slave = driver RAM.
interface led_frame_writer_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              wten;
  logic [ADDR_W-1:0] wtaddr;
  logic [DATA_W-1:0] wtdina;

  modport master (output wten, wtaddr, wtdina);
  modport slave  (input  wten, wtaddr, wtdina);
endinterface

// File: rtl/led_frame_writer.sv
// led_frame_writer -- after a configuration delay, repeatedly emits a frame:
// a start pulse (sdbpflag) followed by one RAM write per LED holding the
// brightness for the latched display mode, scaled by the latched global dim.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   light_flat        : per-LED brightness, LED k at [k*PIX_W +: PIX_W]
//   mode, global_dim  : display mode and global scale, sampled at frame start
//   sdbpflag          : frame-start pulse to the LED driver
//   ram (master)      : wten / wtaddr / wtdina RAM write port
//   busy, frame_done  : frame write in progress / one-cycle end-of-write pulse
module led_frame_writer #(
  parameter int N_LED        = 360,
  parameter int PIX_W        = 8,
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 10,
  parameter int CFG_WAIT     = 2500,
  parameter int FRAME_PERIOD = 420000,
  parameter int PULSE_LEN    = 29,
  parameter int WR_START     = 4,
  parameter int PAT_PERIOD   = 24,
  parameter int CHASE_DIV    = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_LED*PIX_W-1:0]   light_flat,
  input  logic [2:0]               mode,
  input  logic [7:0]               global_dim,
  output logic                     sdbpflag,
  led_frame_writer_if.master       ram,
  output logic                     busy,
  output logic                     frame_done
);
  localparam int FC_W   = $clog2(FRAME_PERIOD);
  localparam int WC_W   = $clog2(CFG_WAIT + 1);
  localparam int DV_W   = $clog2(CHASE_DIV + 1);
  localparam int PH_W   = $clog2(PAT_PERIOD + 1);
  localparam int WR_END = WR_START + N_LED - 1;
  localparam int HALF   = PAT_PERIOD / 2;
  localparam int THIRD  = PAT_PERIOD / 3;
  // Upper band edge taken as period minus a third so the middle band is at
  // least as wide as the top band when the period is not a multiple of 3.
  localparam int TWO_THIRD = PAT_PERIOD - PAT_PERIOD / 3;

  typedef enum logic {S_CFG_WAIT, S_RUN} state_t;

  state_t            state;
  logic [FC_W-1:0]   fc;
  logic [WC_W-1:0]   wait_cnt;
  logic [DV_W-1:0]   div_cnt;
  logic [ADDR_W-1:0] chase_pos;
  logic [PH_W-1:0]   ph;
  logic [2:0]        mode_q;
  logic [7:0]        dim_q;

  logic              run;
  logic              in_wr;
  logic [ADDR_W-1:0] k;
  logic [PIX_W-1:0]  pix;
  logic [DATA_W-1:0] raw;
  logic [DATA_W+8:0] prod;
  logic [DATA_W-1:0] dout;

  always_comb begin
    run   = (state == S_RUN);
    in_wr = run && (fc >= FC_W'(WR_START)) && (fc <= FC_W'(WR_END));
    k     = ADDR_W'(fc - FC_W'(WR_START));
    pix   = '0;
    if (in_wr) pix = light_flat[k*PIX_W +: PIX_W];
    case (mode_q)
      3'd0:    raw = DATA_W'(pix) << (DATA_W - PIX_W);
      3'd1:    raw = '1;
      3'd2:    raw = (ph < PH_W'(HALF)) ? '1 : '0;
      3'd3: begin
        if (ph < PH_W'(THIRD))          raw = '1;
        else if (ph < PH_W'(TWO_THIRD)) raw = DATA_W'(1) << (DATA_W - 8);
        else                            raw = '0;
      end
      3'd4:    raw = (k == chase_pos) ? '1 : '0;
      default: raw = '0;
    endcase
    prod = (DATA_W+9)'(raw) * (DATA_W+9)'({1'b0, dim_q} + 9'd1);
    dout = prod[DATA_W+7:8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_CFG_WAIT;
      fc         <= '0;
      wait_cnt   <= '0;
      div_cnt    <= '0;
      chase_pos  <= '0;
      ph         <= '0;
      mode_q     <= '0;
      dim_q      <= '0;
      sdbpflag   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      ram.wten   <= 1'b0;
      ram.wtaddr <= '0;
      ram.wtdina <= '0;
    end else begin
      // Outputs are a registered image of the current fc.
      sdbpflag   <= run && (fc != '0) && (fc <= FC_W'(PULSE_LEN));
      busy       <= run && (fc <= FC_W'(WR_END));
      frame_done <= run && (fc == FC_W'(WR_END + 1));
      ram.wten   <= in_wr;
      ram.wtaddr <= in_wr ? k : '0;
      ram.wtdina <= in_wr ? dout : '0;

      case (state)
        S_CFG_WAIT: begin
          if (wait_cnt == WC_W'(CFG_WAIT - 1)) state <= S_RUN;
          else wait_cnt <= wait_cnt + WC_W'(1);
        end
        S_RUN: begin
          fc <= (fc == FC_W'(FRAME_PERIOD - 1)) ? '0 : fc + FC_W'(1);
          if (fc == '0) begin
            mode_q <= mode;
            dim_q  <= global_dim;
            ph     <= '0;
            // div_cnt counts frames started since the last step; the step
            // lands at the start of frame CHASE_DIV+1, 2*CHASE_DIV+1, ...
            if (div_cnt == DV_W'(CHASE_DIV)) begin
              div_cnt   <= DV_W'(1);
              chase_pos <= (chase_pos == ADDR_W'(N_LED - 1)) ? '0
                                                             : chase_pos + ADDR_W'(1);
            end else begin
              div_cnt <= div_cnt + DV_W'(1);
            end
          end else if (in_wr) begin
            ph <= (ph == PH_W'(PAT_PERIOD - 1)) ? '0 : ph + PH_W'(1);
          end
        end
        default: state <= S_CFG_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_led_frame_writer.sv
// tb_led_frame_writer -- directed, table-driven bench for led_frame_writer
// with a small configuration (8 LEDs, 40-cycle frames).
module tb_led_frame_writer;
  localparam int N_LED = 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [N_LED*8-1:0]     light_flat;
  logic [2:0]             mode;
  logic [7:0]             global_dim;
  logic                   sdbpflag;
  logic                   busy;
  logic                   frame_done;

  led_frame_writer_if #(.ADDR_W(4), .DATA_W(16)) ram ();

  led_frame_writer #(
    .N_LED(N_LED), .PIX_W(8), .DATA_W(16), .ADDR_W(4), .CFG_WAIT(10),
    .FRAME_PERIOD(40), .PULSE_LEN(4), .WR_START(6), .PAT_PERIOD(4),
    .CHASE_DIV(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .light_flat(light_flat), .mode(mode),
    .global_dim(global_dim), .sdbpflag(sdbpflag), .ram(ram),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int unsigned pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [15:0] cap [N_LED];

  // Waits for the next start pulse, then follows 26 cycles of the frame.
  // t = 0 is the first sample with sdbpflag high (cycle after fc=1).
  task automatic capture_frame(input string nm, input int tog_t,
                               input logic [2:0] tog_mode,
                               output int unsigned rise_cyc);
    int n = 0, sd = 0, wr = 0, dn = 0, bad = 0;
    rise_cyc = 0;
    for (int i = 0; i < N_LED; i++) cap[i] = 16'hDEAD;
    do begin
      @(negedge clk);
      n++;
    end while (sdbpflag !== 1'b1 && n < 60);
    check({nm, " sdbp_rise"}, 32'(sdbpflag), 32'd1);
    if (sdbpflag !== 1'b1) return;
    rise_cyc = pcyc;
    for (int t = 0; t < 26; t++) begin
      if (t > 0) @(negedge clk);
      if (t == tog_t) mode = tog_mode;
      if (sdbpflag) begin sd++; if (t > 3) bad++; end
      if (busy !== (t <= 12)) bad++;
      if (ram.wten) begin
        if (wr < N_LED) begin
          if (int'(ram.wtaddr) != wr || t != 5 + wr) bad++;
          cap[wr] = ram.wtdina;
        end
        wr++;
      end else if (ram.wtaddr != '0 || ram.wtdina != '0) begin
        bad++;
      end
      if (frame_done) begin dn++; if (t != 13) bad++; end
    end
    check({nm, " sdbp_len"},   32'(sd),  32'd4);
    check({nm, " writes"},     32'(wr),  32'd8);
    check({nm, " frame_done"}, 32'(dn),  32'd1);
    check({nm, " timing"},     32'(bad), 32'd0);
  endtask

  task automatic check_data(input string nm, input logic [N_LED-1:0][15:0] exp);
    for (int i = 0; i < N_LED; i++)
      check($sformatf("%s d%0d", nm, i), 32'(cap[i]), 32'(exp[i]));
  endtask

  task automatic do_reset(input logic [2:0] m, input logic [7:0] d);
    @(negedge clk);
    rst_n = 1'b0;
    mode = m;
    global_dim = d;
    repeat (3) @(negedge clk);
    check("reset outputs",
          {27'd0, sdbpflag, busy, frame_done, ram.wten, |ram.wtaddr}, 32'd0);
    check("reset wtdina", 32'(ram.wtdina), 32'd0);
    rst_n = 1'b1;
  endtask

  // exp is packed: element i is the word expected at address i.
  typedef struct {
    logic [2:0]                mode;
    logic [7:0]                dim;
    logic [N_LED-1:0][15:0]    exp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int unsigned r0, r1, r2;
    int quiet;
    int found;
    int first_sd;
    int dn_cnt;
    logic [N_LED-1:0][15:0] cexp;

    // light[k] = k*16 + 1
    light_flat = 64'h71615141_31211101;
    mode = 3'd1;
    global_dim = 8'd255;

    vecs[0] = '{3'd1, 8'd255, {8{16'hFFFF}}};
    vecs[1] = '{3'd0, 8'd255, {16'h7100, 16'h6100, 16'h5100, 16'h4100,
                               16'h3100, 16'h2100, 16'h1100, 16'h0100}};
    vecs[2] = '{3'd0, 8'd127, {16'h3880, 16'h3080, 16'h2880, 16'h2080,
                               16'h1880, 16'h1080, 16'h0880, 16'h0080}};
    vecs[3] = '{3'd2, 8'd255, {16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF,
                               16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF}};
    vecs[4] = '{3'd3, 8'd255, {16'h0000, 16'h0100, 16'h0100, 16'hFFFF,
                               16'h0000, 16'h0100, 16'h0100, 16'hFFFF}};
    vecs[5] = '{3'd3, 8'd127, {16'h0000, 16'h0080, 16'h0080, 16'h7FFF,
                               16'h0000, 16'h0080, 16'h0080, 16'h7FFF}};
    vecs[6] = '{3'd5, 8'd255, {8{16'h0000}}};
    vecs[7] = '{3'd1, 8'd0,   {8{16'h00FF}}};
    vecs[8] = '{3'd0, 8'd0,   {16'h0071, 16'h0061, 16'h0051, 16'h0041,
                               16'h0031, 16'h0021, 16'h0011, 16'h0001}};
    vecs[9] = '{3'd7, 8'd255, {8{16'h0000}}};

    // Configuration delay: ten quiet cycles, busy in the eleventh.
    do_reset(3'd1, 8'd255);
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sdbpflag || busy || frame_done || ram.wten) quiet++;
    end
    check("cfg_wait quiet", 32'(quiet), 32'd0);
    @(negedge clk);
    check("first busy", {30'd0, busy, sdbpflag}, 32'd2);

    capture_frame("frame1", -1, 3'd0, r0);
    check_data("frame1", {8{16'hFFFF}});
    capture_frame("frame2", -1, 3'd0, r1);
    check_data("frame2", {8{16'hFFFF}});
    check("frame period", r1 - r0, 32'd40);

    foreach (vecs[v]) begin
      mode = vecs[v].mode;
      global_dim = vecs[v].dim;
      capture_frame($sformatf("vec%0d", v), -1, 3'd0, r2);
      check_data($sformatf("vec%0d", v), vecs[v].exp);
    end

    // Chase: two frames per step from reset, wrapping after address 7.
    do_reset(3'd4, 8'd255);
    for (int f = 0; f < 20; f++) begin
      cexp = '0;
      cexp[(f / 2) % N_LED] = 16'hFFFF;
      capture_frame($sformatf("chase%0d", f), -1, 3'd0, r2);
      check_data($sformatf("chase%0d", f), cexp);
    end

    // Mode change mid-write only affects the following frame.
    mode = 3'd1;
    capture_frame("toggle_cur", 9, 3'd5, r2);
    check_data("toggle_cur", {8{16'hFFFF}});
    capture_frame("toggle_next", -1, 3'd0, r2);
    check_data("toggle_next", {8{16'h0000}});

    // Reset during the write of address 3 aborts the frame.
    mode = 3'd1;
    found = 0;
    for (int i = 0; i < 80 && found == 0; i++) begin
      @(negedge clk);
      if (ram.wten && ram.wtaddr == 4'd3) found = 1;
    end
    check("abort addr3 seen", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort outputs",
          {27'd0, sdbpflag, busy, frame_done, ram.wten, |ram.wtaddr}, 32'd0);
    check("abort wtdina", 32'(ram.wtdina), 32'd0);
    dn_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (frame_done) dn_cnt++;
    end
    rst_n = 1'b1;
    first_sd = -1;
    for (int i = 1; i <= 40 && first_sd < 0; i++) begin
      @(negedge clk);
      if (frame_done) dn_cnt++;
      if (sdbpflag) first_sd = i;
    end
    check("abort no frame_done", 32'(dn_cnt), 32'd0);
    check("abort restart delay", 32'(first_sd), 32'd12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests %0d failed", tests, fails);
    $fatal(1);
  end
endmodule
